// File: rtl/amult_pkg.sv
// rtl/amult_pkg.sv - shared mode encodings and reference product model
// Contents:
//   amult_mode_e : operating mode encodings
//   amult_ref()  : bit-level reference result for a given W, L, x, y, mode
package amult_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,
    MODE_TRUNC = 2'b01,
    MODE_COMP  = 2'b10,
    MODE_RSVD  = 2'b11
  } amult_mode_e;

  localparam int MAX_W = 16;
  localparam int MAX_PW = 2 * MAX_W;
  localparam logic [MAX_PW-1:0] REF_ONE = {{(MAX_PW-1){1'b0}}, 1'b1};

  // Sums partial-product bits column by column so it shares no structure
  // with the carry-save datapath; the result is reduced modulo 2^(2w).
  function automatic logic [MAX_PW-1:0] amult_ref(
    input int              w,
    input int              l,
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] y,
    input logic [1:0]       mode
  );
    logic [MAX_PW-1:0] acc;
    logic              approx;
    acc    = '0;
    approx = (mode == MODE_TRUNC) || (mode == MODE_COMP);
    for (int i = 0; i < w; i++) begin
      for (int j = 0; j < w; j++) begin
        if (x[i] && y[j] && (!approx || (i + j) >= l)) begin
          acc = acc + (REF_ONE << (i + j));
        end
      end
    end
    if (mode == MODE_COMP) begin
      acc = acc + (REF_ONE << (l - 1));
    end
    if (w < MAX_W) begin
      acc = acc & ((REF_ONE << (2 * w)) - REF_ONE);
    end
    return acc;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// rtl/approx_mult_pipe_if.sv - operand/result handshake bundle
// Signals:
//   in_valid/in_ready, x, y, mode      : operand beat
//   out_valid/out_ready, z, out_mode   : result beat
// Modports: master (beat source / result sink), slave (multiplier)
interface approx_mult_pipe_if #(
  parameter int W = 8
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] z;
  logic [1:0]     out_mode;

  modport master (
    output in_valid, x, y, mode, out_ready,
    input  in_ready, out_valid, z, out_mode
  );

  modport slave (
    input  in_valid, x, y, mode, out_ready,
    output in_ready, out_valid, z, out_mode
  );

endinterface

// File: rtl/amult_csa_tree.sv
// rtl/amult_csa_tree.sv - carry-save reduction of partial-product rows
// Ports:
//   pp_i    in  W rows of 2W bits, already masked for the mode
//   comp_i  in  add the 2^(L-1) compensation constant
//   sum_o   out redundant sum row
//   carry_o out redundant carry row (sum_o + carry_o = product mod 2^(2W))
module amult_csa_tree #(
  parameter int W = 8,
  parameter int L = 6
) (
  input  logic [W-1:0][2*W-1:0] pp_i,
  input  logic                  comp_i,
  output logic [2*W-1:0]        sum_o,
  output logic [2*W-1:0]        carry_o
);

  localparam int PW = 2 * W;
  localparam logic [PW-1:0] COMP_ROW = {{(PW-1){1'b0}}, 1'b1} << (L - 1);

  logic [PW-1:0] acc_s;
  logic [PW-1:0] acc_c;
  logic [PW-1:0] acc_t;

  // The compensation constant rides in as the seed of the sum row, so it
  // costs no extra adder. Each step is a 3:2 compressor; the carry bit
  // shifted out of the top is dropped, giving modulo-2^(2W) arithmetic.
  always_comb begin
    acc_s = comp_i ? COMP_ROW : '0;
    acc_c = '0;
    acc_t = '0;
    for (int j = 0; j < W; j++) begin
      acc_t = acc_s ^ acc_c ^ pp_i[j];
      acc_c = ((acc_s & acc_c) | (acc_s & pp_i[j]) | (acc_c & pp_i[j])) << 1;
      acc_s = acc_t;
    end
    sum_o   = acc_s;
    carry_o = acc_c;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - 3-stage exact/truncated/compensated multiplier
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         approx_mult_pipe_if.slave operand/result handshake
//   cnt_clr     synchronous clear of approx_cnt (wins over increment)
//   approx_cnt  saturating count of accepted mode 01/10 beats
module approx_mult_pipe
  import amult_pkg::*;
#(
  parameter int W  = 8,
  parameter int L  = 6,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  approx_mult_pipe_if.slave   bus,
  input  logic                cnt_clr,
  output logic [CW-1:0]       approx_cnt
);

  localparam int PW = 2 * W;
  // Columns L and above survive truncation; with L = W this is still a
  // plain shift of an all-ones constant, so no zero-width slice appears.
  localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << L;
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  logic en_s1, en_s2, en_s3;
  logic in_fire;
  logic in_approx;

  logic [W-1:0][PW-1:0] pp_d;
  logic [PW-1:0]        row_mask;

  logic                 s1_valid_q;
  logic [W-1:0][PW-1:0] s1_pp_q;
  logic                 s1_comp_q;
  logic [1:0]           s1_mode_q;

  logic [PW-1:0]        csa_sum;
  logic [PW-1:0]        csa_carry;

  logic                 s2_valid_q;
  logic [PW-1:0]        s2_sum_q;
  logic [PW-1:0]        s2_carry_q;
  logic [1:0]           s2_mode_q;

  logic                 s3_valid_q;
  logic [PW-1:0]        z_q;
  logic [PW-1:0]        z_d;
  logic [1:0]           out_mode_q;

  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;

  // A stall can only exist while S3 holds a result, so no upstream stage
  // ever finds all of its downstream stages empty during one: bubble
  // filling under stall never applies and every stage shares the output
  // stage's enable.
  assign en_s3 = !(s3_valid_q && !bus.out_ready);
  assign en_s2 = en_s3;
  assign en_s1 = en_s3;

  assign bus.in_ready = en_s1;
  assign in_fire      = bus.in_valid && en_s1;
  assign in_approx    = (bus.mode == MODE_TRUNC) || (bus.mode == MODE_COMP);
  assign row_mask     = in_approx ? KEEP_MASK : {PW{1'b1}};

  // Row j carries x shifted to weight 2^j, gated by y[j].
  for (genvar j = 0; j < W; j++) begin : g_pp
    assign pp_d[j] = (bus.y[j] ? ({{W{1'b0}}, bus.x} << j) : {PW{1'b0}}) & row_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pp_q    <= '0;
      s1_comp_q  <= 1'b0;
      s1_mode_q  <= MODE_EXACT;
    end else if (en_s1) begin
      s1_valid_q <= in_fire;
      s1_pp_q    <= pp_d;
      s1_comp_q  <= (bus.mode == MODE_COMP);
      s1_mode_q  <= bus.mode;
    end
  end

  amult_csa_tree #(
    .W (W),
    .L (L)
  ) u_csa (
    .pp_i    (s1_pp_q),
    .comp_i  (s1_comp_q),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      s2_mode_q  <= MODE_EXACT;
    end else if (en_s2) begin
      s2_valid_q <= s1_valid_q;
      s2_sum_q   <= csa_sum;
      s2_carry_q <= csa_carry;
      s2_mode_q  <= s1_mode_q;
    end
  end

  assign z_d = s2_sum_q + s2_carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      z_q        <= '0;
      out_mode_q <= MODE_EXACT;
    end else if (en_s3) begin
      s3_valid_q <= s2_valid_q;
      z_q        <= z_d;
      out_mode_q <= s2_mode_q;
    end
  end

  assign bus.out_valid = s3_valid_q;
  assign bus.z         = z_q;
  assign bus.out_mode  = out_mode_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (in_fire && in_approx && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign approx_cnt = cnt_q;

endmodule

// File: doc/approx_mult_pipe.md
APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 Parameter W, default 8: operand width, legal 4..16.
REQ-002 Parameter L, default 6: approximation level, i.e. the number of low product columns affected, legal 1..W.
REQ-003 Parameter CW, default 16: width of the statistics counter.
REQ-004 clk  input  1: single clock, all state on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 in_valid  input  1: operand beat offered.
REQ-007 in_ready  output  1: block accepts beat this cycle.
REQ-008 x  input  W: unsigned multiplicand.
REQ-009 y  input  W: unsigned multiplier.
REQ-010 mode  input  2: 00 exact, 01 truncated, 10 truncated+compensated, 11 reserved.
REQ-011 out_valid  output  1: result beat valid.
REQ-012 out_ready  input  1: downstream accepts result.
REQ-013 z  output  2W: product.
REQ-014 out_mode  output  2: mode that travelled with the result.
REQ-015 approx_cnt  output  CW: count of accepted beats with mode 01 or 10.
REQ-016 cnt_clr  input  1: synchronous clear of approx_cnt.

Function
REQ-017 Partial-product bit p(i,j) = x[i]&y[j] SHALL have weight 2^(i+j).
REQ-018 Mode 00 SHALL produce z = x*y, exact.
REQ-019 Mode 01 SHALL produce z = sum of p(i,j) over i+j >= L; bits with i+j < L are discarded.
REQ-020 Mode 10 SHALL produce the mode-01 value + 2^(L-1), computed modulo 2^(2W).
REQ-021 Mode 11 SHALL behave as mode 00, and out_mode SHALL still report 11.
REQ-022 A handshake SHALL occur on in_valid&&in_ready at input and on out_valid&&out_ready at output.
REQ-023 Pipeline SHALL be 3 stages:
  - S1: register operands and mode, generate the masked partial products.
  - S2: reduce to two rows (carry-save).
  - S3: final carry-propagate add and output register.
REQ-024 Latency with no backpressure SHALL be exactly 3 cycles from input handshake to out_valid.
REQ-025 Throughput with no backpressure SHALL be 1 beat per cycle.
REQ-026 in_ready SHALL equal !(out_valid && !out_ready).
REQ-027 When in_ready is low, all stages SHALL hold, and stage valid bits SHALL hold.
REQ-028 Bubbles SHALL propagate. A stage whose valid bit is low SHALL accept new data even during a global stall only if all downstream stages are empty; otherwise it holds.
REQ-029 z and out_mode SHALL remain stable while out_valid && !out_ready.
REQ-030 Results SHALL leave in acceptance order; no beat is dropped or duplicated.
REQ-031 approx_cnt SHALL increment by 1 on each input handshake with mode 01 or 10.
REQ-032 approx_cnt SHALL saturate at 2^CW-1.
REQ-033 When cnt_clr coincides with an increment, the clear SHALL win and approx_cnt becomes 0.
REQ-034 When L = W the mode-01 datapath SHALL still compile, with no zero-width slices.

Reset
REQ-035 On rst_n low: all stage valid bits 0, out_valid 0, z 0, out_mode 00, approx_cnt 0.
REQ-036 in_ready SHALL be 1 during and immediately after reset.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight beats; no result SHALL appear after release unless new input is accepted.

Structure
REQ-038 Shared package amult_pkg SHALL hold:
  - mode encodings: MODE_EXACT, MODE_TRUNC, MODE_COMP, MODE_RSVD;
  - a function returning the reference model result for given W, L, x, y, mode.
REQ-039 Sub-module amult_csa_tree (parametrised W, L) SHALL implement the S2 reduction, one instance.
REQ-040 The stage-advance/stall logic SHALL be a single enable per stage within approx_mult_pipe.

Verification
REQ-041 W=8, L=6, x=255, y=255, one beat per mode -> z = 65025 (00), 64704 (01), 64736 (10), 65025 with out_mode 11 (11), each exactly 3 cycles after input.
REQ-042 W=8, L=6, x=3, y=3 -> mode 01 gives z=0, mode 10 gives z=32, mode 00 gives z=9.
REQ-043 Hold out_ready=0 for 5 cycles with 4 beats in flight -> in_ready low while blocked, z stable, all 4 results in order after release, none lost.
REQ-044 Random back-to-back stream of 10k beats with random out_ready -> every z matches the package model, and approx_cnt equals the number of mode 01/10 beats.
REQ-045 Assert rst_n low with 3 beats in flight -> out_valid 0 and approx_cnt 0 immediately, and no stale beat emerges after release.
REQ-046 CW=4, 20 approximate beats -> approx_cnt saturates at 15; cnt_clr pulsed together with an approximate beat -> approx_cnt = 0.
